contador_m_ud: RTL

CONTADOR_M_UD -- requirements
Module: contador_m_ud

---
 rtl/contador_m_ud_if.sv | 26 ++
 rtl/contador_m_ud.sv | 103 ++++++++++
 2 files changed

// File: rtl/contador_m_ud_if.sv
// contador_m_ud bus: control, load data and count/status outputs.
// master drives controls, slave is the counter itself.
interface contador_m_ud_if #(
  parameter int N = 13
);
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] D;
  logic         conta;
  logic         desce;
  logic [N-1:0] Q;
  logic         fim;
  logic         meio;
  logic         rco;
  logic [7:0]   voltas;

  modport master (
    output zera_s, carrega, D, conta, desce,
    input  Q, fim, meio, rco, voltas
  );

  modport slave (
    input  zera_s, carrega, D, conta, desce,
    output Q, fim, meio, rco, voltas
  );
endinterface

// File: rtl/contador_m_ud.sv
// Modulo-M up/down counter with clear, clamped load, wrap or saturate,
// end-of-range pulse and an 8-bit event counter.
module contador_m_ud #(
  parameter int M      = 5000,
  parameter int N      = 13,
  parameter bit SATURA = 1'b0
) (
  input logic clock,
  input logic zera_as,
  contador_m_ud_if.slave bus
);

  localparam logic [N-1:0] QMAX = N'(M - 1);
  localparam logic [N-1:0] QMID = N'(M / 2);

  typedef enum logic {
    RUN,
    HELD
  } st_t;

  st_t          st_q, st_d;
  logic [N-1:0] q_q, q_d;
  logic [7:0]   v_q, v_d;
  logic         rco_q, rco_d;

  logic at_end;
  logic do_clr;
  logic do_ld;
  logic do_step;
  logic do_evt;

  assign at_end  = bus.desce ? (q_q == '0) : (q_q == QMAX);
  assign do_clr  = bus.zera_s;
  assign do_ld   = ~bus.zera_s & bus.carrega;
  assign do_step = ~bus.zera_s & ~bus.carrega
                 & bus.conta & ~at_end;
  assign do_evt  = ~bus.zera_s & ~bus.carrega
                 & bus.conta & at_end;

  always_ff @(posedge clock or negedge zera_as) begin
    if (!zera_as) begin
      st_q  <= RUN;
      q_q   <= '0;
      v_q   <= '0;
      rco_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      q_q   <= q_d;
      v_q   <= v_d;
      rco_q <= rco_d;
    end
  end

  // HELD marks a saturated end value; any edge that moves Q drops it
  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      do_clr:  st_d = RUN;
      do_ld:   st_d = RUN;
      do_step: st_d = RUN;
      do_evt:  st_d = SATURA ? HELD : RUN;
      default: st_d = st_q;
    endcase
  end

  always_comb begin
    q_d   = q_q;
    v_d   = v_q;
    rco_d = 1'b0;
    unique case (1'b1)
      do_clr: begin
        q_d = '0;
        v_d = '0;
      end
      do_ld: begin
        q_d = (bus.D > QMAX) ? QMAX : bus.D;
      end
      do_step: begin
        q_d = bus.desce ? (q_q - 1'b1) : (q_q + 1'b1);
      end
      do_evt: begin
        if (SATURA == 1'b0) begin
          q_d   = bus.desce ? QMAX : '0;
          rco_d = 1'b1;
          v_d   = v_q + 8'd1;
        end else if (st_q == RUN) begin
          rco_d = 1'b1;
          v_d   = v_q + 8'd1;
        end
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  assign bus.Q      = q_q;
  assign bus.fim    = at_end;
  assign bus.meio   = (q_q == QMID);
  assign bus.rco    = rco_q;
  assign bus.voltas = v_q;

endmodule
